matrix_memory: RTL and testbench
================================

# matrix_memory

- Single-port matrix data memory on the CPU's shared 262-bit tri-state bus.
- Each word holds one 256-bit matrix: 4×4 elements, 16 bits each, row-major, element [0][0] in bits 255:240.
- The execution engine controls the block through strobes:
  - first it loads an address from the bus;
  - then it either drives a stored matrix onto the bus, or captures a bus value into memory;
  - a dedicated "over" strobe stores an ALU overflow word into the next-higher address.

## Interface
Parameters:
- DEPTH, 128: number of 256-bit words; must be a power of two.
- ADDR_W, 7: address width, log2(DEPTH).
- DATA_W, 256: stored word width.
- BUS_W, 262: shared bus width.

Ports:
- clock  input  1  single system clock; all state updates on rising edge.
- reset  input  1  reset; synchronous and active-high.
- bus  inout  BUS_W  shared tri-state system bus.
- write  input  1  store bus[DATA_W-1:0] at the held address.
- importAddress  input  1  latch bus[ADDR_W-1:0] into the address register.
- read  input  1  drive the addressed word onto the bus.
- enable  input  1  master enable; all other strobes are ignored when 0.
- over  input  1  store bus[DATA_W-1:0] at (held address + 1).

## Operation
- **Address register** `addr` (ADDR_W bits).
  - Loaded at a rising edge when enable & importAddress.
  - Upper bus bits are ignored.
- **Read path** (combinational, no clock involved).
  - While enable & read: bus = {6'b0, mem[addr]}.
  - Otherwise the block drives all-Z.
  - The block never drives the bus during reset.
- **Write priority** at a rising edge with enable=1, highest first:
  1. importAddress: address load only, no store.
  2. read: no store; read wins and write/over are ignored.
  3. over: mem[(addr+1) mod DEPTH] <= bus[DATA_W-1:0].
  4. write: mem[addr] <= bus[DATA_W-1:0].
- When over and write are asserted together, only the addr+1 store happens; mem[addr] is unchanged.
- Address wrap: addr=DEPTH-1 with over stores to word 0.
- bus bits [261:256] are ignored on all stores.
- enable=0: no state changes and no bus drive, regardless of the other strobes.
- `addr` persists across operations until the next import.

## Timing
- Address load takes effect at the edge where importAddress is sampled; a read asserted from the next cycle on sees the new address.
- Read latency is zero cycles: data is valid on the bus within the same cycle read & enable rise. Stable for sampling anywhere before the next edge.
- A store is visible to a read in the cycle after the storing edge.
- Reset (rising edge with reset=1):
  - addr <= 0;
  - any strobes asserted in that cycle are ignored;
  - bus output is Z while reset=1;
  - memory contents are retained unless MATMEM_RESET_CLEAR_EN is defined.
- Reset mid-sequence (address loaded, write pending): the pending store is dropped, and the next store needs a fresh address import.
- Power-up state before first reset: memory contents and addr are 0.

## Configuration
- MATMEM_RESET_CLEAR_EN:
  - **Defined:** a synchronous reset also zeroes every memory word in the same edge.
  - **Undefined:** reset affects only addr and the bus driver; stored matrices survive reset.

## Structure
- Shared package `matrix_cpu_pkg` holds:
  - BUS_W, DATA_W, ADDR_W, DEPTH, ELEM_W=16, MAT_DIM=4;
  - typedef matrix_t (DATA_W logic vector);
  - typedef mat_addr_t (ADDR_W).
- One natural sub-module: `bus_tristate_driver` (parameter BUS_W; inputs oe and data; inout bus). Reused by the other bus agents (ALU, instruction memory, registers).
- Storage array, address register and priority logic are written inline in matrix_memory.

## Test plan
1. Import 0x05, write 256'h0001…0010; next cycle import 0x05, read → bus == {6'b0, 256'h0001…0010}. With read low → bus all-Z.
2. Import 0x7F, assert write+over with bus=256'hAAAA…: word 0x00 == 256'hAAAA…, word 0x7F unchanged (wrap + priority).
3. enable=0 with importAddress/write/read asserted, bus=0x11: addr unchanged, no store, bus not driven by block.
4. Simultaneous importAddress+write with bus=0x0C: addr becomes 0x0C, mem[old addr] and mem[0x0C] unchanged.
5. Store at 0x03, then reset one cycle, then read without import:
   - bus returns mem[0x00] (addr cleared);
   - re-import 0x03 returns the stored value (without macro), or 0 (with MATMEM_RESET_CLEAR_EN).
6. read+write together at addr 0x10 with a different bus value from a second driver: memory keeps its old value, and the block drives the stored word.

Source files
------------

// File: rtl/matrix_cpu_pkg.sv
// -----------------------------------------------------------------------------
// matrix_cpu_pkg
//   Shared definitions for the matrix CPU bus agents: bus/data/address widths,
//   matrix geometry and the word/address types used by the data memory.
//   A matrix word is 4x4 elements of 16 bits, row-major, with element [0][0]
//   in the most significant 16 bits.
// -----------------------------------------------------------------------------
package matrix_cpu_pkg;

   localparam int unsigned BUS_W   = 262;
   localparam int unsigned DATA_W  = 256;
   localparam int unsigned DEPTH   = 128;
   localparam int unsigned ADDR_W  = $clog2(DEPTH);
   localparam int unsigned ELEM_W  = 16;
   localparam int unsigned MAT_DIM = 4;

   typedef logic [DATA_W-1:0] matrix_t;
   typedef logic [ADDR_W-1:0] mat_addr_t;
   typedef logic [ELEM_W-1:0] mat_elem_t;

   // Element [row][col] of a row-major matrix word; [0][0] sits at the top.
   function automatic mat_elem_t mat_get_elem(input matrix_t m, input int unsigned row,
                                              input int unsigned col);
      int unsigned idx;
      idx = row * MAT_DIM + col;
      return m[DATA_W - 1 - idx * ELEM_W -: ELEM_W];
   endfunction

   // Returns m with element [row][col] replaced by e.
   function automatic matrix_t mat_set_elem(input matrix_t m, input int unsigned row,
                                            input int unsigned col, input mat_elem_t e);
      matrix_t     r;
      int unsigned idx;
      r   = m;
      idx = row * MAT_DIM + col;
      r[DATA_W - 1 - idx * ELEM_W -: ELEM_W] = e;
      return r;
   endfunction

endpackage

// File: rtl/bus_tristate_driver.sv
// -----------------------------------------------------------------------------
// bus_tristate_driver
//   Drives a value onto the shared tri-state system bus while oe is high and
//   releases the bus (all-Z) otherwise. Shared by every agent on the bus.
//
//   Ports:
//     oe    in     1      output enable
//     data  in     BUS_W  value to drive
//     bus   inout  BUS_W  shared system bus
// -----------------------------------------------------------------------------
module bus_tristate_driver #(
   parameter int unsigned BUS_W = 262
) (
   input  logic             oe,
   input  logic [BUS_W-1:0] data,
   inout  wire  [BUS_W-1:0] bus
);

   assign bus = oe ? data : {BUS_W{1'bz}};

endmodule

// File: rtl/matrix_memory.sv
// -----------------------------------------------------------------------------
// matrix_memory
//   Single-port matrix data memory on the shared system bus. Each word holds
//   one 4x4 matrix of 16-bit elements. The execution engine first imports an
//   address from the bus, then either reads the addressed word onto the bus
//   (combinational) or stores a bus value. The "over" strobe stores an ALU
//   overflow word at the next-higher address (wrapping at DEPTH).
//
//   Strobe priority at a rising edge with enable=1:
//     importAddress > read > over > write
//
//   Ports:
//     clock          in     1      system clock, rising edge
//     reset          in     1      synchronous, active-high
//     bus            inout  BUS_W  shared tri-state bus
//     write          in     1      store bus[DATA_W-1:0] at addr
//     importAddress  in     1      load bus[ADDR_W-1:0] into addr
//     read           in     1      drive {0, mem[addr]} onto the bus
//     enable         in     1      master enable for all other strobes
//     over           in     1      store bus[DATA_W-1:0] at addr+1
//
//   Configuration macro:
//     MATMEM_RESET_CLEAR_EN  when defined, reset also zeroes every word;
//                            otherwise stored matrices survive reset.
// -----------------------------------------------------------------------------
module matrix_memory
   import matrix_cpu_pkg::*;
#(
   parameter int unsigned DEPTH  = matrix_cpu_pkg::DEPTH,
   parameter int unsigned ADDR_W = matrix_cpu_pkg::ADDR_W,
   parameter int unsigned DATA_W = matrix_cpu_pkg::DATA_W,
   parameter int unsigned BUS_W  = matrix_cpu_pkg::BUS_W
) (
   input  logic             clock,
   input  logic             reset,
   inout  wire  [BUS_W-1:0] bus,
   input  logic             write,
   input  logic             importAddress,
   input  logic             read,
   input  logic             enable,
   input  logic             over
);

   // Power-up state is all zero, before any reset is applied.
   logic [ADDR_W-1:0] addr_q = '0;
   logic [ADDR_W-1:0] addr_d;
   logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

   logic [ADDR_W-1:0] addr_inc;
   logic              store_en;
   logic [ADDR_W-1:0] store_addr;
   logic [DATA_W-1:0] store_data;

   logic              rd_oe;
   logic [BUS_W-1:0]  rd_data;

   // Bus bits above the data field carry nothing for this block.
   logic              unused_bus_hi;
   assign unused_bus_hi = ^bus[BUS_W-1:DATA_W];

   // Wraps naturally at DEPTH since DEPTH is a power of two.
   assign addr_inc   = addr_q + ADDR_W'(1);
   assign store_data = bus[DATA_W-1:0];

   // ---------------------------------------------------------------------------
   // Strobe decode: one action per edge, highest priority first.
   // ---------------------------------------------------------------------------
   always_comb begin
      addr_d     = addr_q;
      store_en   = 1'b0;
      store_addr = addr_q;
      if (enable) begin
         if (importAddress) begin
            addr_d = bus[ADDR_W-1:0];
         end else if (read) begin
            // Bus carries our own read data; nothing is stored.
            store_en = 1'b0;
         end else if (over) begin
            store_en   = 1'b1;
            store_addr = addr_inc;
         end else if (write) begin
            store_en   = 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Address register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (reset) begin
         addr_q <= '0;
      end else begin
         addr_q <= addr_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Storage array
   // ---------------------------------------------------------------------------
   always_ff @(posedge clock) begin
`ifdef MATMEM_RESET_CLEAR_EN
      if (reset) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem[i] <= '0;
         end
      end else if (store_en) begin
         mem[store_addr] <= store_data;
      end
`else
      // Reset drops any store in flight but leaves contents intact.
      if (!reset && store_en) begin
         mem[store_addr] <= store_data;
      end
`endif
   end

   // ---------------------------------------------------------------------------
   // Read path: zero-latency, never driven during reset.
   // ---------------------------------------------------------------------------
   assign rd_oe   = enable & read & ~reset;
   assign rd_data = {{(BUS_W - DATA_W){1'b0}}, mem[addr_q]};

   bus_tristate_driver #(
      .BUS_W (BUS_W)
   ) u_bus_drv (
      .oe   (rd_oe),
      .data (rd_data),
      .bus  (bus)
   );

endmodule

// File: tb/tb_matrix_memory.sv
// -----------------------------------------------------------------------------
// tb_matrix_memory
//   Self-checking bench for matrix_memory. A word-array model of the memory and
//   its address register is updated at every rising edge from the strobe rules;
//   bus values are compared in the same cycle as the strobes (zero latency).
//   Where the block must not drive, the bench drives a known value itself and
//   expects to see exactly that value on the bus.
// -----------------------------------------------------------------------------
module tb_matrix_memory;
   import matrix_cpu_pkg::*;

   logic             clock = 1'b0;
   logic             reset;
   logic             write;
   logic             importAddress;
   logic             read;
   logic             enable;
   logic             over;
   wire  [BUS_W-1:0] bus;

   logic [BUS_W-1:0] tb_drive;
   logic             tb_oe;

   assign bus = tb_oe ? tb_drive : {BUS_W{1'bz}};

   always #5 clock = ~clock;

   matrix_memory dut (
      .clock         (clock),
      .reset         (reset),
      .bus           (bus),
      .write         (write),
      .importAddress (importAddress),
      .read          (read),
      .enable        (enable),
      .over          (over)
   );

   // Reference model
   logic [DATA_W-1:0] model_mem [DEPTH];
   int                model_addr;
   int                vectors;
   int                miscompares;

   function automatic logic [BUS_W-1:0] exp_read();
      return {{(BUS_W - DATA_W){1'b0}}, model_mem[model_addr]};
   endfunction

   function automatic logic [BUS_W-1:0] rand_bus();
      logic [287:0] t;
      for (int i = 0; i < 9; i++) t[i*32 +: 32] = $urandom;
      return t[BUS_W-1:0];
   endfunction

   // Apply strobes just after a falling edge; the bench drives the bus unless
   // the block is expected to drive it (or force_oe requests contention).
   task automatic set_in(input logic rst, input logic en, input logic imp, input logic rd,
                         input logic wr, input logic ov, input logic [BUS_W-1:0] val,
                         input logic force_oe);
      @(negedge clock);
      reset         = rst;
      enable        = en;
      importAddress = imp;
      read          = rd;
      write         = wr;
      over          = ov;
      tb_drive      = val;
      tb_oe         = force_oe | ~(en & rd & ~rst);
      #1;
   endtask

   // Rising edge: advance the model from the strobes currently applied.
   task automatic clock_edge();
      logic [BUS_W-1:0] bus_val;
      bus_val = tb_oe ? tb_drive : exp_read();
      @(posedge clock);
      if (reset) begin
         model_addr = 0;
`ifdef MATMEM_RESET_CLEAR_EN
         for (int i = 0; i < int'(DEPTH); i++) model_mem[i] = '0;
`endif
      end else if (enable) begin
         if (importAddress)   model_addr = int'(bus_val[ADDR_W-1:0]);
         else if (read)       model_addr = model_addr;
         else if (over)       model_mem[(model_addr + 1) % DEPTH] = bus_val[DATA_W-1:0];
         else if (write)      model_mem[model_addr] = bus_val[DATA_W-1:0];
      end
      #1;
   endtask

   task automatic op(input logic rst, input logic en, input logic imp, input logic rd,
                     input logic wr, input logic ov, input logic [BUS_W-1:0] val);
      set_in(rst, en, imp, rd, wr, ov, val, 1'b0);
      clock_edge();
   endtask

   task automatic do_import(input int a);
      op(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, BUS_W'(a));
   endtask

   // ---------------------------------------------------------------------------
   task automatic test_reset();
      op(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
      op(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
      set_in(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
      vectors++;
      if (bus !== {BUS_W{1'b0}}) begin
         miscompares++;
         $display("FAIL reset_read_word0: got %h expected 0", bus);
      end
      clock_edge();
   endtask

   task automatic test_basic(input logic [DATA_W-1:0] pat);
      do_import(5);
      op(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, {6'b111111, pat});
      do_import(5);
      set_in(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
      vectors++;
      if (bus !== {6'b0, pat}) begin
         miscompares++;
         $display("FAIL basic_read: got %h expected %h", bus, {6'b0, pat});
      end
      clock_edge();
      // read low: only the bench's zero drive may appear
      set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
      vectors++;
      if (bus !== {BUS_W{1'b0}}) begin
         miscompares++;
         $display("FAIL basic_no_drive: got %h expected 0", bus);
      end
      clock_edge();
   endtask

   task automatic test_wrap();
      logic [DATA_W-1:0] w7f;
      logic [DATA_W-1:0] aaaa;
      w7f  = rand_bus();
      aaaa = {(DATA_W/16){16'hAAAA}};
      do_import(8'h7F);
      op(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, {6'b0, w7f});
      op(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, {6'b0, aaaa});
      do_import(0);
      set_in(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
      vectors++;
      if (bus !== {6'b0, aaaa}) begin
         miscompares++;
         $display("FAIL wrap_word0: got %h expected %h", bus, {6'b0, aaaa});
      end
      clock_edge();
      do_import(8'h7F);
      set_in(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
      vectors++;
      if (bus !== {6'b0, w7f}) begin
         miscompares++;
         $display("FAIL wrap_word7f_kept: got %h expected %h", bus, {6'b0, w7f});
      end
      clock_edge();
   endtask

   task automatic test_disable(input logic [DATA_W-1:0] pat);
      do_import(5);
      set_in(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, BUS_W'(8'h11), 1'b0);
      vectors++;
      if (bus !== BUS_W'(8'h11)) begin
         miscompares++;
         $display("FAIL disable_no_drive: got %h expected %h", bus, BUS_W'(8'h11));
      end
      clock_edge();
      set_in(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
      vectors++;
      if (bus !== {6'b0, pat}) begin
         miscompares++;
         $display("FAIL disable_state_kept: got %h expected %h", bus, {6'b0, pat});
      end
      clock_edge();
   endtask

   task automatic test_import_write(input logic [DATA_W-1:0] pat);
      do_import(5);
      op(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, BUS_W'(8'h0C));
      set_in(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
      vectors++;
      if (bus !== {BUS_W{1'b0}}) begin
         miscompares++;
         $display("FAIL import_write_0c: got %h expected 0", bus);
      end
      clock_edge();
      do_import(5);
      set_in(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
      vectors++;
      if (bus !== {6'b0, pat}) begin
         miscompares++;
         $display("FAIL import_write_old: got %h expected %h", bus, {6'b0, pat});
      end
      clock_edge();
   endtask

   task automatic test_reset_midseq();
      logic [DATA_W-1:0] r1;
      logic [DATA_W-1:0] r2;
      logic [BUS_W-1:0]  e0;
      logic [BUS_W-1:0]  e3;
      r1 = rand_bus();
      r2 = rand_bus();
      r1[0] = 1'b1;
      do_import(3);
      op(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, {6'b0, r1});
      do_import(0);
      op(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, {6'b0, r2});
      do_import(3);
      // reset with read+write pending: no drive, no store
      set_in(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0);
      vectors++;
      if (bus !== {BUS_W{1'b0}}) begin
         miscompares++;
         $display("FAIL reset_no_drive: got %h expected 0", bus);
      end
      clock_edge();
`ifdef MATMEM_RESET_CLEAR_EN
      e0 = '0;
      e3 = '0;
`else
      e0 = {6'b0, r2};
      e3 = {6'b0, r1};
`endif
      set_in(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
      vectors++;
      if (bus !== e0) begin
         miscompares++;
         $display("FAIL reset_addr_cleared: got %h expected %h", bus, e0);
      end
      clock_edge();
      do_import(3);
      set_in(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
      vectors++;
      if (bus !== e3) begin
         miscompares++;
         $display("FAIL reset_contents: got %h expected %h", bus, e3);
      end
      clock_edge();
   endtask

   task automatic test_read_priority();
      logic [DATA_W-1:0] old_v;
      logic [DATA_W-1:0] new_v;
      old_v = rand_bus();
      new_v = ~old_v;
      do_import(8'h10);
      op(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, {6'b0, old_v});
      set_in(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
      vectors++;
      if (bus !== {6'b0, old_v}) begin
         miscompares++;
         $display("FAIL prio_drive: got %h expected %h", bus, {6'b0, old_v});
      end
      clock_edge();
      // second driver fights the read while write and over are also high
      set_in(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, {6'b0, new_v}, 1'b1);
      clock_edge();
      set_in(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
      vectors++;
      if (bus !== {6'b0, old_v}) begin
         miscompares++;
         $display("FAIL prio_word_kept: got %h expected %h", bus, {6'b0, old_v});
      end
      clock_edge();
      op(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, BUS_W'(8'h11));
      set_in(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
      vectors++;
      if (bus !== exp_read()) begin
         miscompares++;
         $display("FAIL prio_over_dropped: got %h expected %h", bus, exp_read());
      end
      clock_edge();
   endtask

   task automatic test_random(input int n);
      logic             rst, en, imp, rd, wr, ov;
      logic [BUS_W-1:0] val;
      logic [BUS_W-1:0] exp;
      for (int i = 0; i < n; i++) begin
         rst = ($urandom % 25) == 0;
         en  = ($urandom % 8) != 0;
         imp = ($urandom % 4) == 0;
         rd  = ($urandom % 3) == 0;
         wr  = ($urandom % 2) == 0;
         ov  = ($urandom % 5) == 0;
         val = rand_bus();
         // keep addresses clustered so words get reused, including the wrap
         if (($urandom % 4) != 0) val[ADDR_W-1:0] = ADDR_W'(($urandom % 10) + 120);
         set_in(rst, en, imp, rd, wr, ov, val, 1'b0);
         exp = (en && rd && !rst) ? exp_read() : val;
         vectors++;
         if (bus !== exp) begin
            miscompares++;
            $display("FAIL random_%0d: got %h expected %h", i, bus, exp);
         end
         clock_edge();
      end
   endtask

   // ---------------------------------------------------------------------------
   initial begin
      logic [DATA_W-1:0] pat;
      vectors       = 0;
      miscompares   = 0;
      model_addr    = 0;
      for (int i = 0; i < int'(DEPTH); i++) model_mem[i] = '0;
      reset         = 1'b1;
      enable        = 1'b0;
      importAddress = 1'b0;
      read          = 1'b0;
      write         = 1'b0;
      over          = 1'b0;
      tb_drive      = '0;
      tb_oe         = 1'b1;
      for (int e = 0; e < 16; e++) pat[DATA_W - 1 - e*16 -: 16] = 16'(e + 1);

      test_reset();
      test_basic(pat);
      test_wrap();
      test_disable(pat);
      test_import_write(pat);
      test_reset_midseq();
      test_read_priority();
      test_random(400);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: timeout expired, expected completion");
      $fatal(1, "timeout");
   end

endmodule
